pdp8_mem_arb: RTL
=================

PDP8_MEM_ARB -- requirements
Module: pdp8_mem_arb

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2: clocks a memory strobe is held per access (legal 1-15).
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive CPU grants allowed while DMA waits (legal 1-15).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-005 cpu_addr  in  15  CPU word address (field:addr).
REQ-006 cpu_data_in  in  12  CPU write data.
REQ-007 cpu_rd / cpu_wr  in  1 each  CPU level requests; held until cpu_ack.
REQ-008 cpu_data_out  out  12  registered CPU read data.
REQ-009 cpu_ack  out  1  one-cycle pulse; CPU access complete.
REQ-010 dma_read_req / dma_write_req  in  1 each  DMA level requests; held until dma_done.
REQ-011 dma_ma  in  15  DMA word address; dma_in  in  12  DMA write data.
REQ-012 dma_out  out  12  registered DMA read data; dma_done  out  1  one-cycle completion pulse.
REQ-013 mem_addr  out  15; mem_data_out  out  12; mem_rd / mem_wr  out  1 each; mem_data_in  in  12: shared RAM port.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-015 FSM states: IDLE, CPU_ACC, DMA_ACC, COMPLETE; all state and outputs are registered.
REQ-016 IDLE: no request -> stay; only CPU pending -> CPU_ACC; only DMA pending -> DMA_ACC.
REQ-017 Both pending in IDLE -> CPU_ACC, unless starve_cnt == STARVE_LIMIT, in which case -> DMA_ACC.
REQ-018 starve_cnt (4 bits): increments on each CPU grant made while DMA is pending; clears on any DMA grant and whenever DMA is not pending; saturates at STARVE_LIMIT.
REQ-019 On grant, address, write data and direction are latched; later changes on request inputs do not affect the access in flight.
REQ-020 rd and wr asserted together by one requester: the access is a write, and no read data is returned.
REQ-021 In CPU_ACC/DMA_ACC, mem_rd or mem_wr is held high for exactly ACCESS_CYCLES clocks, with mem_addr and mem_data_out stable for the whole window.
REQ-022 Read data is sampled from mem_data_in on the last strobe cycle into cpu_data_out or dma_out; the other requester's data register is unchanged.
REQ-023 COMPLETE lasts one cycle: strobes are low, and cpu_ack or dma_done pulses for exactly that cycle, then the FSM returns to IDLE.
REQ-024 Latency from request to ack/done with the port idle: ACCESS_CYCLES+2 clocks (grant, strobes, complete).
REQ-025 Mem_rd and mem_wr are never both high; at most one of cpu_ack and dma_done is high in any cycle.
REQ-026 A request withdrawn mid-access does not abort the access; it completes and ack/done still pulses.
REQ-027 A request still held in the cycle after its ack/done is treated as a new request.

Reset
REQ-028 While reset is low: state=IDLE, starve_cnt=0, access counter=0, mem_rd=mem_wr=0, cpu_ack=dma_done=0, busy=0, mem_addr=0, mem_data_out=0, cpu_data_out=0, dma_out=0.
REQ-029 Reset asserted mid-access aborts the access immediately, and no ack or done is issued for it.
REQ-030 After reset deasserts, the first grant occurs no earlier than the first clk edge following deassertion.

Verification
REQ-031 CPU read only: cpu_addr=15'o07400, mem returns 12'o1234, ACCESS_CYCLES=2 -> mem_rd high 2 clocks, cpu_ack in clock 4, cpu_data_out=12'o1234.
REQ-032 DMA write only: dma_ma=15'o00020, dma_in=12'o7777 -> mem_wr high 2 clocks with stable address and data, then a single dma_done pulse; cpu_ack stays low.
REQ-033 CPU and DMA requesting continuously, STARVE_LIMIT=4 -> grant order is CPU x4, DMA, CPU x4, DMA, ...; mem_rd and mem_wr are never high together.
REQ-034 cpu_rd and cpu_wr both asserted -> a write is performed and cpu_data_out is unchanged.
REQ-035 Reset low during the second strobe cycle of a DMA read -> mem_rd drops asynchronously, no dma_done is issued, and after release a pending CPU request is granted normally.
REQ-036 cpu_rd dropped after grant -> the access completes, and cpu_ack pulses exactly once.

Source files
------------

// File: rtl/pdp8_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_mem_arb_if
// Brief    : Bus bundle for pdp8_mem_arb: CPU port, DMA port, shared RAM port.
// Revision : 1.0
// ============================================================================
interface pdp8_mem_arb_if;
  logic [14:0] cpu_addr;
  logic [11:0] cpu_data_in;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [11:0] cpu_data_out;
  logic        cpu_ack;

  logic        dma_read_req;
  logic        dma_write_req;
  logic [14:0] dma_ma;
  logic [11:0] dma_in;
  logic [11:0] dma_out;
  logic        dma_done;

  logic [14:0] mem_addr;
  logic [11:0] mem_data_out;
  logic        mem_rd;
  logic        mem_wr;
  logic [11:0] mem_data_in;

  logic        busy;

  // Requesters and RAM side
  modport master (
    output cpu_addr, cpu_data_in, cpu_rd, cpu_wr,
    output dma_read_req, dma_write_req, dma_ma, dma_in,
    output mem_data_in,
    input  cpu_data_out, cpu_ack, dma_out, dma_done,
    input  mem_addr, mem_data_out, mem_rd, mem_wr, busy
  );

  // Arbiter side
  modport slave (
    input  cpu_addr, cpu_data_in, cpu_rd, cpu_wr,
    input  dma_read_req, dma_write_req, dma_ma, dma_in,
    input  mem_data_in,
    output cpu_data_out, cpu_ack, dma_out, dma_done,
    output mem_addr, mem_data_out, mem_rd, mem_wr, busy
  );
endinterface
`default_nettype wire

// File: rtl/pdp8_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_mem_arb
// Brief    : CPU/DMA arbiter for one shared PDP-8 RAM port, with DMA anti-starvation.
// Revision : 1.0
// ============================================================================
module pdp8_mem_arb #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic          clk,
  input  logic          reset,
  pdp8_mem_arb_if.slave bus
);

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_cpu      = 2'd1;
  localparam logic [1:0] c_st_dma      = 2'd2;
  localparam logic [1:0] c_st_complete = 2'd3;

  localparam logic [3:0] c_acc_load   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] c_starve_max = 4'(STARVE_LIMIT);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  r_acc_cnt;
  logic        r_is_dma;
  logic        r_is_write;
  logic [14:0] r_mem_addr;
  logic [11:0] r_mem_data;
  logic [11:0] r_cpu_data;
  logic [11:0] r_dma_data;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_cpu_ack;
  logic        r_dma_done;
  logic        r_busy;

  logic        w_cpu_pend;
  logic        w_dma_pend;
  logic        w_starved;
  logic        w_grant_cpu;
  logic        w_grant_dma;
  logic        w_last_strobe;
  logic        w_sel_write;
  logic        w_write_nxt;
  logic        w_in_acc_nxt;
  logic        w_mem_rd_nxt;
  logic        w_mem_wr_nxt;
  logic        w_cpu_ack_nxt;
  logic        w_dma_done_nxt;
  logic        w_busy_nxt;

  assign w_cpu_pend  = bus.cpu_rd | bus.cpu_wr;
  assign w_dma_pend  = bus.dma_read_req | bus.dma_write_req;
  assign w_starved   = (r_starve_cnt == c_starve_max);
  // rd+wr together from one requester is treated as a write
  assign w_sel_write = w_grant_dma ? bus.dma_write_req : bus.cpu_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_cpu   = 1'b0;
    w_grant_dma   = 1'b0;
    w_last_strobe = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_dma_pend && (!w_cpu_pend || w_starved)) begin
          w_grant_dma = 1'b1;
          w_state_nxt = c_st_dma;
        end else if (w_cpu_pend) begin
          w_grant_cpu = 1'b1;
          w_state_nxt = c_st_cpu;
        end
      end
      c_st_cpu, c_st_dma: begin
        if (r_acc_cnt == 4'd0) begin
          w_last_strobe = 1'b1;
          w_state_nxt   = c_st_complete;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers
  always_comb begin
    w_write_nxt    = (w_grant_cpu | w_grant_dma) ? w_sel_write : r_is_write;
    w_in_acc_nxt   = (w_state_nxt == c_st_cpu) || (w_state_nxt == c_st_dma);
    w_mem_rd_nxt   = w_in_acc_nxt & ~w_write_nxt;
    w_mem_wr_nxt   = w_in_acc_nxt &  w_write_nxt;
    w_cpu_ack_nxt  = (w_state_nxt == c_st_complete) & ~r_is_dma;
    w_dma_done_nxt = (w_state_nxt == c_st_complete) &  r_is_dma;
    w_busy_nxt     = (w_state_nxt != c_st_idle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_dma_done <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_mem_rd   <= w_mem_rd_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_cpu_ack  <= w_cpu_ack_nxt;
      r_dma_done <= w_dma_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
      r_acc_cnt    <= 4'd0;
      r_is_dma     <= 1'b0;
      r_is_write   <= 1'b0;
      r_mem_addr   <= 15'd0;
      r_mem_data   <= 12'd0;
      r_cpu_data   <= 12'd0;
      r_dma_data   <= 12'd0;
    end else begin
      if (!w_dma_pend || w_grant_dma) begin
        r_starve_cnt <= 4'd0;
      end else if (w_grant_cpu && (r_starve_cnt != c_starve_max)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      if (w_grant_cpu || w_grant_dma) begin
        r_is_dma   <= w_grant_dma;
        r_is_write <= w_sel_write;
        r_mem_addr <= w_grant_dma ? bus.dma_ma : bus.cpu_addr;
        r_mem_data <= w_grant_dma ? bus.dma_in : bus.cpu_data_in;
        r_acc_cnt  <= c_acc_load;
      end else if (((r_state == c_st_cpu) || (r_state == c_st_dma)) && (r_acc_cnt != 4'd0)) begin
        r_acc_cnt <= r_acc_cnt - 4'd1;
      end

      if (w_last_strobe && !r_is_write) begin
        if (r_is_dma) begin
          r_dma_data <= bus.mem_data_in;
        end else begin
          r_cpu_data <= bus.mem_data_in;
        end
      end
    end
  end

  assign bus.mem_rd       = r_mem_rd;
  assign bus.mem_wr       = r_mem_wr;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_data_out = r_mem_data;
  assign bus.cpu_ack      = r_cpu_ack;
  assign bus.dma_done     = r_dma_done;
  assign bus.cpu_data_out = r_cpu_data;
  assign bus.dma_out      = r_dma_data;
  assign bus.busy         = r_busy;

endmodule
`default_nettype wire
